// File: rtl/cordic_seq_pkg.sv
// Shared types and constants for the CORDIC request sequencer.
package cordic_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    localparam logic FUNC_SIGMOID = 1'b0;

endpackage

// File: rtl/cordic_seq_fifo.sv
// Small synchronous FIFO holding {func, x} operand words for the sequencer.
module cordic_seq_fifo #(
    parameter int DW    = 33,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [DW-1:0]    wdata_i,
    output logic [DW-1:0]    rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PTR_W:0]   count_o
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [DW-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    // A full FIFO refuses the push even when a pop frees a slot this cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the count gates every read, so stale words are never seen.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/cordic_req_sequencer.sv
// Feeds buffered operands to the cordic_final core one at a time and collects
// its results into a single-entry output slot, aborting hung operations.
module cordic_req_sequencer
    import cordic_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int FRAC    = 14,
    parameter int DEPTH   = 4,
    parameter int PTR_W   = 2,
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic             in_func,
    output logic             core_start,
    output logic [WIDTH-1:0] core_x,
    output logic             core_func,
    input  logic             core_busy,
    input  logic             core_done,
    input  logic [WIDTH:0]   core_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_result,
    output logic             out_func,
    output logic             out_err
);

    localparam int             DW      = WIDTH + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT);

    if (FRAC >= WIDTH || DEPTH < 2 || DEPTH != (1 << PTR_W) || TIMEOUT >= (1 << TO_W)) begin : g_param_check
        $error("cordic_req_sequencer: inconsistent parameters");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] core_x_q, core_x_d;
    logic             core_func_q, core_func_d;
    logic [TO_W-1:0]  wd_q, wd_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH:0]   out_result_q, out_result_d;
    logic             out_func_q, out_func_d;
    logic             out_err_q, out_err_d;

    logic             push, pop;
    logic [DW-1:0]    head;
    logic             fifo_full, fifo_empty;
    logic [PTR_W:0]   fifo_count;

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;

    cordic_seq_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({in_func, in_x}),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    a_full_matches_count: assert property (@(posedge clk) disable iff (rst)
        fifo_full == (fifo_count == (PTR_W+1)'(DEPTH)));

    always_comb begin
        state_d      = state_q;
        core_x_d     = core_x_q;
        core_func_d  = core_func_q;
        wd_d         = wd_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_func_d   = out_func_q;
        out_err_d    = out_err_q;
        pop          = 1'b0;

        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        case (state_q)
            // Never issue into a busy core or while an unread result occupies the slot.
            ST_IDLE: begin
                if (!fifo_empty && !out_valid_q && !core_busy) begin
                    pop         = 1'b1;
                    core_x_d    = head[WIDTH-1:0];
                    core_func_d = head[WIDTH];
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wd_d    = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                wd_d = wd_q + 1'b1;
                // Done is checked first so it wins over a coincident timeout.
                if (core_done) begin
                    out_result_d = core_result;
                    out_func_d   = core_func_q;
                    out_err_d    = 1'b0;
                    out_valid_d  = 1'b1;
                    state_d      = ST_IDLE;
                end else if (wd_d == TO_LAST) begin
                    out_result_d = '0;
                    out_func_d   = core_func_q;
                    out_err_d    = 1'b1;
                    out_valid_d  = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            core_x_q     <= '0;
            core_func_q  <= FUNC_SIGMOID;
            wd_q         <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_func_q   <= FUNC_SIGMOID;
            out_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            core_x_q     <= core_x_d;
            core_func_q  <= core_func_d;
            wd_q         <= wd_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_func_q   <= out_func_d;
            out_err_q    <= out_err_d;
        end
    end

    assign core_start = (state_q == ST_ISSUE);
    assign core_x     = core_x_q;
    assign core_func  = core_func_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_func   = out_func_q;
    assign out_err    = out_err_q;

endmodule

// File: tb/tb_cordic_req_sequencer.sv
// Directed bench for cordic_req_sequencer with a behavioural stand-in core:
// func 0 returns x + 100, func 1 returns -x, LAT+1 cycles after start is seen.
module tb_cordic_req_sequencer;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;
    localparam int LAT     = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_x = '0;
    logic             in_func = 1'b0;
    logic             core_start;
    logic [WIDTH-1:0] core_x;
    logic             core_func;
    logic             core_busy;
    logic             core_done;
    logic [WIDTH:0]   core_result;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH:0]   out_result;
    logic             out_func;
    logic             out_err;

    always #5 clk = ~clk;

    cordic_req_sequencer #(
        .WIDTH(32), .FRAC(14), .DEPTH(DEPTH), .PTR_W(2), .TIMEOUT(TIMEOUT), .TO_W(7)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_func     (in_func),
        .core_start  (core_start),
        .core_x      (core_x),
        .core_func   (core_func),
        .core_busy   (core_busy),
        .core_done   (core_done),
        .core_result (core_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_func    (out_func),
        .out_err     (out_err)
    );

    // Behavioural core stand-in.
    logic           mdl_busy = 1'b0;
    logic           mdl_done = 1'b0;
    logic [WIDTH:0] mdl_res  = '0;
    logic [WIDTH-1:0] mdl_x  = '0;
    logic           mdl_f    = 1'b0;
    int             mdl_cnt  = 0;
    logic           hang = 1'b0, kill = 1'b0, stale_done = 1'b0;

    assign core_busy   = mdl_busy;
    assign core_done   = mdl_done | stale_done;
    assign core_result = mdl_res;

    always @(posedge clk) begin
        mdl_done <= 1'b0;
        if (kill) begin
            mdl_busy <= 1'b0;
        end else if (core_start) begin
            mdl_busy <= 1'b1;
            mdl_cnt  <= LAT;
            mdl_x    <= core_x;
            mdl_f    <= core_func;
        end else if (mdl_busy && !hang) begin
            if (mdl_cnt == 0) begin
                mdl_busy <= 1'b0;
                mdl_done <= 1'b1;
                mdl_res  <= mdl_f ? -{mdl_x[WIDTH-1], mdl_x} : {mdl_x[WIDTH-1], mdl_x} + 33'd100;
            end else begin
                mdl_cnt <= mdl_cnt - 1;
            end
        end
    end

    // Start-pulse and operand-stability observer.
    int   n_start = 0, bad_start = 0, unstable = 0, since_done = -1;
    int   gap_log [256];
    logic prev_start = 1'b0;
    logic mon_en = 1'b1;

    always @(negedge clk) begin
        if (since_done >= 0) since_done++;
        if (core_done) since_done = 0;
        if (core_start) begin
            if (core_busy || prev_start) bad_start++;
            if (n_start < 256) gap_log[n_start] = (since_done >= 0) ? since_done - 1 : -1;
            n_start++;
            since_done = -1;
        end
        prev_start = core_start;
        if (mon_en && mdl_busy && (core_x != mdl_x || core_func != mdl_f)) unstable++;
    end

    int total = 0, bad = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] x, input logic f);
        int n = 0;
        in_valid = 1'b1;
        in_x     = x;
        in_func  = f;
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("push_timeout", n, 0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input longint res, input logic f, input logic e);
        int n = 0;
        while (!out_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_res"}, $signed(out_result), res);
        check({tag, "_func"}, out_func, f);
        check({tag, "_err"}, out_err, e);
        @(negedge clk);
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (!core_start && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_start_seen"}, core_start, 1);
    endtask

    initial begin
        int s0, cnt, seen;

        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_core_start", core_start, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_result", $signed(out_result), 0);
        check("rst_out_err", out_err, 0);
        check("rst_core_x", core_x, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single op: start in the cycle after the push edge.
        s0 = n_start;
        push(32'd8192, 1'b0);
        check("t1_start_early", core_start, 0);
        @(negedge clk);
        check("t1_start", core_start, 1);
        check("t1_core_x", core_x, 8192);
        expect_out("t1", 8292, 1'b0, 1'b0);
        check("t1_nstart", n_start - s0, 1);

        // Back-to-back burst, mixed functions and signs.
        s0 = n_start;
        fork
            begin
                push(32'd0, 1'b0);
                push(32'd4096, 1'b1);
                push(-32'sd4096, 1'b0);
                push(-32'sd16384, 1'b1);
            end
            begin
                expect_out("b0", 100, 1'b0, 1'b0);
                expect_out("b1", -4096, 1'b1, 1'b0);
                expect_out("b2", -3996, 1'b0, 1'b0);
                expect_out("b3", 16384, 1'b1, 1'b0);
            end
        join
        check("b_nstart", n_start - s0, 4);
        for (int i = 1; i < 4; i++) check($sformatf("b_gap%0d_le2", i), gap_log[s0 + i] <= 2, 1);

        // Backpressure: one op in flight into the slot, then DEPTH more fill the FIFO.
        out_ready = 1'b0;
        s0 = n_start;
        for (int k = 1; k <= DEPTH + 1; k++) push(32'(k * 10), 1'b0);
        check("bp_full", in_ready, 0);
        cnt = 0;
        while (!out_valid && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        for (int k = 0; k < 4; k++) begin
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_res", $signed(out_result), 110);
            @(negedge clk);
        end
        check("bp_nstart", n_start - s0, 1);
        fork
            push(32'd60, 1'b0);
            begin
                out_ready = 1'b1;
                for (int k = 1; k <= DEPTH + 2; k++)
                    expect_out($sformatf("bp%0d", k), 100 + 10 * k, 1'b0, 1'b0);
            end
        join

        // Watchdog: the core never finishes.
        hang = 1'b1;
        s0 = n_start;
        push(32'd500, 1'b1);
        wait_start("wd");
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!out_valid && cnt < 200);
        check("wd_latency", cnt, TIMEOUT + 1);
        check("wd_err", out_err, 1);
        check("wd_res", $signed(out_result), 0);
        @(negedge clk);
        check("wd_consumed", out_valid, 0);
        stale_done = 1'b1;
        @(negedge clk);
        stale_done = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("wd_stale_ignored", seen, 0);
        check("wd_nstart", n_start - s0, 1);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        hang = 1'b0;

        // Reset while waiting on the core.
        push(32'd700, 1'b0);
        wait_start("rw");
        @(negedge clk);
        mon_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rw_out_valid", out_valid, 0);
        check("rw_in_ready", in_ready, 1);
        check("rw_fifo_count", dut.u_fifo.count_o, 0);
        check("rw_core_x", core_x, 0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rw_no_output", seen, 0);
        mon_en = 1'b1;
        push(32'd16384, 1'b0);
        expect_out("rw_after", 16484, 1'b0, 1'b0);

        check("start_pulse_rules", bad_start, 0);
        check("operand_stable", unstable, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
